fact_table_writer: RTL and testbench
====================================

// Module: fact_table_writer
// PURPOSE
//   Computes k! for k = 0..N with an iterative 64x8 shift-add multiplier.
//   Writes each 64-bit result into the 256x64 result RAM at address BASE+k.
//   Sits directly upstream of the RAM: drives its cen/wen/s_addr/s_din write port.
//   The downstream reader then fetches results from the RAM by address.
// PARAMETERS
//   ADDR_W    8    RAM address width; address arithmetic wraps modulo 2**ADDR_W
//   DATA_W    64   RAM word width / factorial result width
//   K_W       8    width of op_n and of the multiplier operand k
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous reset, active-high
//   op_start     in   1       start request; sampled only in IDLE
//   op_n         in   K_W     highest k to compute (0..255)
//   op_base      in   ADDR_W  RAM address that receives 0!
//   op_busy      out  1       1 in every state except IDLE
//   op_done      out  1       one-cycle pulse when the run ends
//   op_overflow  out  1       sticky per run: k! exceeded DATA_W bits; cleared on next accepted start
//   m_cen        out  1       RAM chip enable
//   m_wen        out  1       RAM write enable (always equal to m_cen)
//   m_addr       out  ADDR_W  RAM address
//   m_din        out  DATA_W  RAM write data
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - All outputs are registered or decoded from registered state.
//   - Reset: state=IDLE; op_busy=0, op_done=0, op_overflow=0, m_cen=0, m_wen=0, m_addr=0, m_din=0.
//   - Reset mid-run aborts the run: m_cen=0 from the cycle after the reset edge; no further writes.
//   - FSM IDLE -> WRITE -> (MUL -> WRITE)* -> [STATUS] -> DONE -> IDLE.
//   - IDLE: at an edge with op_start=1, latch n and base; set k=0, acc=1, op_overflow=0; go to WRITE.
//   - WRITE: exactly one cycle with m_cen=m_wen=1, m_addr=base+k (mod 256), m_din=acc.
//       If k==n, go to DONE (or to STATUS when the macro below is defined).
//       Otherwise k<=k+1 and go to MUL.
//   - MUL: exactly 8 cycles, one multiplier bit per cycle, LSB first.
//       Uses a 72-bit accumulator: prod += acc<<i when k[i]=1.
//       After the 8th cycle: if prod[71:64]!=0, set op_overflow=1 and go to DONE without writing k!.
//       Else acc<=prod[63:0] and go to WRITE.
//   - Latency: first write 1 cycle after start is accepted. A clean run takes 1+9n cycles to the last write.
//   - DONE: op_done=1 for exactly one cycle; return to IDLE.
//   - op_start while busy is ignored.
//   - Largest n that completes without overflow is 20 (20! = 0x21C3677C82B40000).
//   - Outside WRITE/STATUS: m_cen=m_wen=0, and m_addr/m_din hold their last values.
// CONFIGURATION
//   FACT_STATUS_WORD_EN defined:
//     After the final WRITE (or on overflow), one extra write cycle in state STATUS.
//     m_addr=base+last_k+1 (mod 256); m_din={op_overflow, 47'b0, 8'(last_k), 8'(n)}.
//     last_k is the last k successfully written. DONE follows 1 cycle later.
//   FACT_STATUS_WORD_EN undefined: STATUS state absent; no extra write.
// STRUCTURE
//   Package fact_pkg:
//     state encoding (IDLE, WRITE, MUL, STATUS, DONE);
//     MUL_STEPS=8; FACT_MAX_NO_OVF=20; constant FACT20=64'h21C3677C82B40000.
//   Sub-module fact_shift_add_mul: 64x8 multi-cycle multiplier.
//     Ports: start, a[63:0], b[7:0] in; busy, done, p[71:0] out.
//     The FSM here sequences it and owns all RAM signals.
// TESTING (bench pairs the block with the RAM model and reads back after done)
//   n=0, base=0x00 -> one write, addr 0x00 data 1; op_done 2 cycles after start accept; overflow=0.
//   n=5, base=0x10 -> 0x10..0x15 = 1,1,2,6,24,120; last write 46 cycles after accept.
//   n=20, base=0x40 -> 0x54 = 0x21C3677C82B40000; op_overflow=0.
//   n=25, base=0x00 -> writes 0..20 only; 0x15 stays 0; op_overflow=1; op_done pulses once.
//   n=3, base=0xFE -> writes at 0xFE,0xFF,0x00,0x01 = 1,1,2,6 (address wrap).
//   rst held 1 cycle during MUL of n=10; op_start re-pulsed while busy -> ignored.
//     After reset: m_cen=0, op_busy=0, op_done=0, and no further writes.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial table writer.
package fact_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StMul,
        StStatus,
        StDone
    } fact_state_e;

    localparam int unsigned MUL_STEPS       = 8;
    localparam int unsigned FACT_MAX_NO_OVF = 20;
    localparam logic [63:0] FACT20          = 64'h21C3677C82B40000;

    // Layout of the optional trailing status word.
    function automatic logic [63:0] status_word(input logic       ovf,
                                                input logic [7:0] last_k,
                                                input logic [7:0] n);
        return {ovf, 47'b0, last_k, n};
    endfunction

endpackage

// File: rtl/fact_table_writer_if.sv
// Operation handshake plus RAM write port of the factorial table writer.
interface fact_table_writer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned K_W    = 8
);
    logic              op_start;
    logic [K_W-1:0]    op_n;
    logic [ADDR_W-1:0] op_base;
    logic              op_busy;
    logic              op_done;
    logic              op_overflow;
    logic              m_cen;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;

    modport master (
        output op_start, op_n, op_base,
        input  op_busy, op_done, op_overflow, m_cen, m_wen, m_addr, m_din
    );

    modport slave (
        input  op_start, op_n, op_base,
        output op_busy, op_done, op_overflow, m_cen, m_wen, m_addr, m_din
    );
endinterface

// File: rtl/fact_shift_add_mul.sv
// Multi-cycle A_W x B_W shift-add multiplier, one multiplier bit per cycle, LSB first.
module fact_shift_add_mul
    import fact_pkg::*;
#(
    parameter int unsigned A_W = 64,
    parameter int unsigned B_W = MUL_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [A_W+B_W-1:0] p
);
    localparam int unsigned S_W = $clog2(B_W);

    logic [A_W-1:0]     a_q;
    logic [B_W-1:0]     b_q;
    logic [A_W+B_W-1:0] prod_q, prod_d;
    logic [S_W-1:0]     step_q;
    logic               busy_q;

    always_comb begin
        prod_d = prod_q;
        if (b_q[step_q]) begin
            prod_d = prod_q + ({{B_W{1'b0}}, a_q} << step_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= '0;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            prod_q <= prod_d;
            step_q <= step_q + S_W'(1);
            if (step_q == S_W'(B_W - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The final product is presented during the last step so the caller can act on that edge.
    assign busy = busy_q;
    assign done = busy_q && (step_q == S_W'(B_W - 1));
    assign p    = prod_d;

endmodule

// File: rtl/fact_table_writer.sv
// Computes k! for k = 0..n and writes each result to RAM at base+k.
// Define FACT_STATUS_WORD_EN to append a status word after the last result.
module fact_table_writer
    import fact_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned K_W    = 8
) (
    input logic                clk,
    input logic                rst,
    fact_table_writer_if.slave bus
);
    localparam int unsigned P_W = DATA_W + K_W;

    fact_state_e       state_q, state_d;
    logic [K_W-1:0]    n_q, n_d, k_q, k_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [DATA_W-1:0] acc_q, acc_d, din_q, din_d;
    logic              ovf_q, ovf_d;
`ifdef FACT_STATUS_WORD_EN
    logic [K_W-1:0]    last_k_q, last_k_d;
`endif

    logic           mul_start, mul_busy, mul_done;
    logic [K_W-1:0] mul_b;
    logic [P_W-1:0] mul_p;

    assign mul_b = k_q + K_W'(1);

    fact_shift_add_mul #(
        .A_W(DATA_W),
        .B_W(K_W)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(mul_start),
        .a    (acc_q),
        .b    (mul_b),
        .busy (mul_busy),
        .done (mul_done),
        .p    (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        base_d    = base_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        addr_d    = addr_q;
        din_d     = din_q;
        mul_start = 1'b0;
`ifdef FACT_STATUS_WORD_EN
        last_k_d  = last_k_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.op_start) begin
                    n_d     = bus.op_n;
                    base_d  = bus.op_base;
                    k_d     = '0;
                    acc_d   = DATA_W'(1);
                    ovf_d   = 1'b0;
                    addr_d  = bus.op_base;
                    din_d   = DATA_W'(1);
                    state_d = StWrite;
                end
            end
            StWrite: begin
`ifdef FACT_STATUS_WORD_EN
                last_k_d = k_q;
`endif
                if (k_q == n_q) begin
`ifdef FACT_STATUS_WORD_EN
                    addr_d  = base_q + ADDR_W'(k_q) + ADDR_W'(1);
                    din_d   = DATA_W'(status_word(ovf_q, 8'(k_q), 8'(n_q)));
                    state_d = StStatus;
`else
                    state_d = StDone;
`endif
                end else begin
                    k_d       = k_q + K_W'(1);
                    mul_start = 1'b1;
                    state_d   = StMul;
                end
            end
            StMul: begin
                if (mul_done) begin
                    if (|mul_p[P_W-1:DATA_W]) begin
                        ovf_d = 1'b1;
`ifdef FACT_STATUS_WORD_EN
                        // k_q is already last_k+1 here.
                        addr_d  = base_q + ADDR_W'(k_q);
                        din_d   = DATA_W'(status_word(1'b1, 8'(last_k_q), 8'(n_q)));
                        state_d = StStatus;
`else
                        state_d = StDone;
`endif
                    end else begin
                        acc_d   = mul_p[DATA_W-1:0];
                        addr_d  = base_q + ADDR_W'(k_q);
                        din_d   = mul_p[DATA_W-1:0];
                        state_d = StWrite;
                    end
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; abandon the run rather than hang.
                    state_d = StIdle;
                end
            end
            StStatus: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            n_q      <= '0;
            k_q      <= '0;
            base_q   <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
`ifdef FACT_STATUS_WORD_EN
            last_k_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
`ifdef FACT_STATUS_WORD_EN
            last_k_q <= last_k_d;
`endif
        end
    end

    assign bus.op_busy     = (state_q != StIdle);
    assign bus.op_done     = (state_q == StDone);
    assign bus.op_overflow = ovf_q;
    assign bus.m_cen       = (state_q == StWrite) || (state_q == StStatus);
    assign bus.m_wen       = bus.m_cen;
    assign bus.m_addr      = addr_q;
    assign bus.m_din       = din_q;

endmodule

// File: tb/tb_fact_table_writer.sv
// Scoreboard bench for fact_table_writer with a behavioural 256x64 RAM.
module tb_fact_table_writer;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fact_table_writer_if bus ();

    fact_table_writer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_wr_cyc = -1;
    logic [63:0] mem [256];
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model plus scoreboard pop on every write cycle.
    always @(negedge clk) begin
        wr_t e;
        if (bus.m_cen === 1'b1) begin
            mem[bus.m_addr] = bus.m_din;
            last_wr_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h, required no write",
                         bus.m_addr, bus.m_din);
            end else begin
                e = exp_q.pop_front();
                if (bus.m_addr !== e.addr || bus.m_din !== e.data || bus.m_wen !== 1'b1) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h wen=%b, required addr=%h data=%h wen=1",
                             bus.m_addr, bus.m_din, bus.m_wen, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_expected(input int n, input logic [7:0] base,
                                 output int last_k, output bit ovf);
        logic [127:0] f;
        f = 128'd1;
        last_k = 0;
        ovf = 1'b0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) f = f * k;
            if (f[127:64] != 0) begin
                ovf = 1'b1;
                break;
            end
            exp_q.push_back('{addr: base + 8'(k), data: f[63:0]});
            last_k = k;
        end
`ifdef FACT_STATUS_WORD_EN
        exp_q.push_back('{addr: base + 8'(last_k + 1),
                          data: {ovf, 47'b0, 8'(last_k), 8'(n)}});
`endif
    endtask

    task automatic run_op(input int n, input logic [7:0] base);
        int  last_k, a_cyc, d_cyc, pulses, exp_done, exp_last;
        bit  ovf;
        push_expected(n, base, last_k, ovf);
        @(negedge clk);
        bus.op_start = 1'b1;
        bus.op_n     = 8'(n);
        bus.op_base  = base;
        a_cyc = cyc;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        d_cyc  = -1;
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.op_done === 1'b1) begin
                pulses++;
                if (d_cyc < 0) d_cyc = cyc;
            end
            if (d_cyc >= 0 && bus.op_busy === 1'b0) break;
        end
        exp_done = ovf ? 1 + 9 * (last_k + 1) : 2 + 9 * n;
        exp_last = 1 + 9 * last_k;
`ifdef FACT_STATUS_WORD_EN
        exp_done = exp_done + 1;
        exp_last = exp_done - 1;
`endif
        checks++;
        if (d_cyc - a_cyc !== exp_done) begin
            failures++;
            $display("FAIL done_latency n=%0d got %0d, required %0d", n, d_cyc - a_cyc, exp_done);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL done_pulses n=%0d got %0d, required 1", n, pulses);
        end
        checks++;
        if (last_wr_cyc - a_cyc !== exp_last) begin
            failures++;
            $display("FAIL last_write_latency n=%0d got %0d, required %0d",
                     n, last_wr_cyc - a_cyc, exp_last);
        end
        checks++;
        if (bus.op_overflow !== ovf) begin
            failures++;
            $display("FAIL overflow n=%0d got %b, required %b", n, bus.op_overflow, ovf);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL missing_writes n=%0d got %0d pending, required 0", n, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.op_start = 1'b0;
        bus.op_n     = '0;
        bus.op_base  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.m_cen, bus.m_wen, bus.op_busy, bus.op_done, bus.op_overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got cen=%b wen=%b busy=%b done=%b ovf=%b, required all 0",
                     bus.m_cen, bus.m_wen, bus.op_busy, bus.op_done, bus.op_overflow);
        end
        checks++;
        if (bus.m_addr !== 8'h00 || bus.m_din !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus got addr=%h din=%h, required 0/0", bus.m_addr, bus.m_din);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_op(0, 8'h00);
        checks++;
        if (mem[8'h00] !== 64'd1) begin
            failures++;
            $display("FAIL n0_mem got %h, required 1", mem[8'h00]);
        end
    endtask

    task automatic test_overflow();
        run_op(25, 8'h00);
        checks++;
        if (mem[8'h14] !== 64'h21C3677C82B40000) begin
            failures++;
            $display("FAIL ovf_mem20 got %h, required 21c3677c82b40000", mem[8'h14]);
        end
        checks++;
        if (mem[8'h15] !== 64'h0) begin
            failures++;
            $display("FAIL ovf_mem21 got %h, required 0", mem[8'h15]);
        end
    endtask

    task automatic test_small();
        logic [63:0] tbl [6];
        tbl = '{64'd1, 64'd1, 64'd2, 64'd6, 64'd24, 64'd120};
        run_op(5, 8'h10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[8'h10 + 8'(i)] !== tbl[i]) begin
                failures++;
                $display("FAIL n5_mem[%0d] got %0d, required %0d", i, mem[8'h10 + 8'(i)], tbl[i]);
            end
        end
    endtask

    task automatic test_max();
        run_op(20, 8'h40);
        checks++;
        if (mem[8'h54] !== 64'h21C3677C82B40000) begin
            failures++;
            $display("FAIL n20_mem got %h, required 21c3677c82b40000", mem[8'h54]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  adr [4];
        logic [63:0] val [4];
        adr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        val = '{64'd1, 64'd1, 64'd2, 64'd6};
        run_op(3, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[adr[i]] !== val[i]) begin
                failures++;
                $display("FAIL wrap_mem[%h] got %0d, required %0d", adr[i], mem[adr[i]], val[i]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int  a_cyc;
        bit  saw_cen;
        exp_q.push_back('{addr: 8'h80, data: 64'd1});
        @(negedge clk);
        bus.op_start = 1'b1;
        bus.op_n     = 8'd10;
        bus.op_base  = 8'h80;
        a_cyc = cyc;
        @(posedge clk);
        #1 bus.op_start = 1'b0;
        while (cyc < a_cyc + 3) @(negedge clk);
        // Start re-pulsed during MUL must be ignored.
        bus.op_start = 1'b1;
        bus.op_n     = 8'd2;
        bus.op_base  = 8'hC0;
        @(negedge clk);
        bus.op_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.m_cen, bus.op_busy, bus.op_done} !== 3'b000) begin
            failures++;
            $display("FAIL midrun_reset got cen=%b busy=%b done=%b, required 0/0/0",
                     bus.m_cen, bus.op_busy, bus.op_done);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_cen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.m_cen !== 1'b0 || bus.op_busy !== 1'b0) saw_cen = 1'b1;
        end
        checks++;
        if (saw_cen !== 1'b0) begin
            failures++;
            $display("FAIL midrun_quiet got activity=%b, required 0", saw_cen);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL midrun_first_write got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        test_reset();
        test_single();
        test_overflow();
        test_small();
        test_max();
        test_wrap();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
